seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised time-multiplexed driver for common-anode/cathode seven-segment banks.
- Scans DIGITS digits at SCAN_FREQ frames/s.
- Adds per-digit blanking mask, 16-level brightness PWM, an anti-ghosting guard gap between digits, frame-synchronous data capture (no tearing) and configurable output polarity.
- Sits between the display-data formatter (BCD/segment decoders) and the FPGA pins.

Parameters:
- DIGITS, 6, number of digits scanned (1..16).
- SEG_W, 8, segment bits per digit (7 segments + dp).
- CLK_FREQ, 50000000, clk frequency in Hz.
- SCAN_FREQ, 200, full-frame refresh rate in Hz.
- GUARD, 2, blank cycles at the start of every digit slot (anti-ghosting).
- SEL_ACTIVE_LOW, 1, 1: seg_sel bit low = digit on; 0: high = on.
- SEG_ACTIVE_LOW, 1, 1: seg_data bit low = segment lit; 0: high = lit.
- Derived: DWELL = CLK_FREQ/(SCAN_FREQ*DIGITS) cycles per slot. Must satisfy DWELL > GUARD + 1; checked at elaboration.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  global display enable; 0 blanks outputs, scan keeps running.
- bright  in  4  brightness 0..15.
- digit_en  in  DIGITS  per-digit enable mask; bit i = 0 blanks digit i.
- seg_data_in  in  DIGITS*SEG_W  logical segment data, active-high (1 = lit); digit i at [i*SEG_W +: SEG_W].
- seg_sel  out  DIGITS  registered digit select, physical polarity.
- seg_data  out  SEG_W  registered segment drive, physical polarity.
- digit_idx  out  4  index of the slot currently being scanned.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- State:
  - slot timer t (0..DWELL-1).
  - digit index idx (0..DIGITS-1).
  - shadow registers for seg_data_in and digit_en.
  - latched brightness b.
- Each clk: if t == DWELL-1, t <= 0 and idx <= (idx == DIGITS-1) ? 0 : idx+1; else t <= t+1. idx wraps DIGITS-1 -> 0, never exceeds DIGITS-1.
- Frame boundary (idx == 0 && t == 0):
  - shadow data/mask <= seg_data_in/digit_en.
  - frame_start <= 1 (registered, so it is high the following cycle); otherwise frame_start <= 0.
  - Input changes mid-frame do not appear until the next frame.
- Slot start (t == 0, every slot): b <= bright. Brightness changes take effect at slot granularity and never truncate an in-progress on-window.
- on_len = ((DWELL-GUARD)*(b+1)) >> 4. Computed with at least 32-bit width, no overflow. b = 15 gives the full window DWELL-GUARD. on_len may be 0 at low b with small DWELL; that slot is then dark.
- lit = en && shadow_mask[idx] && (t >= GUARD) && (t < GUARD+on_len).
- Output registers update on every clk from the current (idx, t); outputs lag the state by exactly one cycle.
- When lit:
  - seg_sel: only bit idx active.
  - seg_data = shadow_data[idx], inverted if SEG_ACTIVE_LOW.
- When not lit:
  - seg_sel: all bits inactive.
  - seg_data: all segments off.
- Two digits are never active in the same cycle.
- digit_idx <= idx, registered with the same one-cycle lag.
- Off values:
  - seg_sel inactive = all 1s if SEL_ACTIVE_LOW, else all 0s.
  - seg_data off = all 1s if SEG_ACTIVE_LOW, else all 0s.
- Reset (asynchronous, any time, including mid-slot):
  - t = 0, idx = 0, b = 0, shadows = 0.
  - seg_sel inactive, seg_data off, digit_idx = 0, frame_start = 0.
- First cycle after reset release is a frame boundary: capture happens and frame_start pulses one cycle later.
- DIGITS == 1: every slot is a frame boundary, so frame_start pulses every DWELL cycles.

Test Plan:
- Test configuration: DIGITS=4, CLK_FREQ=3200, SCAN_FREQ=50, GUARD=2, DWELL=16, active-low polarities.
- Full scan, bright=15, en=1, mask=4'hF, data digit i = 8'h11*(i+1):
  - each 16-cycle slot gives 2 cycles all-off, then 14 cycles with seg_sel=~(1<<i) and seg_data=~(8'h11*(i+1)).
  - order 0,1,2,3,0; frame_start pulses every 64 cycles.
- bright=7: on-window is 7 cycles per slot (cycles 2..8 of slot). bright=0: on_len=0, display dark.
- Mask and enable:
  - digit_en=4'b1010: digits 0 and 2 stay dark for their full slots; timing unchanged.
  - en=0 mid-slot: outputs off from the next cycle.
- Tearing: change seg_data_in while idx=2. Digits 2 and 3 keep the old values for the rest of the frame; new values appear from the next frame_start.
- Reset: assert rstn=0 mid-slot while lit. seg_sel=4'hF and seg_data=8'hFF immediately (asynchronous). After release, scan restarts at digit 0 with frame_start one cycle later.
- Polarity: repeat scenario 1 with SEL_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0; outputs are bitwise complements of scenario 1, with off state = all 0s.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan driver with blanking mask,
// 16-level PWM brightness, guard gap and frame-synchronous capture.
module seg_scan_ctrl #(
    parameter int DIGITS         = 6,
    parameter int SEG_W          = 8,
    parameter int CLK_FREQ       = 50000000,
    parameter int SCAN_FREQ      = 200,
    parameter int GUARD          = 2,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [3:0]                bright,
    input  logic [DIGITS-1:0]         digit_en,
    input  logic [DIGITS*SEG_W-1:0]   seg_data_in,
    output logic [DIGITS-1:0]         seg_sel,
    output logic [SEG_W-1:0]          seg_data,
    output logic [3:0]                digit_idx,
    output logic                      frame_start
);

    localparam int DWELL = CLK_FREQ / (SCAN_FREQ * DIGITS);
    localparam int TW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [31:0]       WIN     = 32'(DWELL - GUARD);
    localparam logic [31:0]       G       = 32'(GUARD);

    generate
        if (DWELL <= GUARD + 1) begin : g_bad_dwell
            $error("seg_scan_ctrl: DWELL must exceed GUARD+1");
        end
    endgenerate

    logic [TW-1:0]           t;
    logic [IW-1:0]           idx;
    logic [DIGITS*SEG_W-1:0] shadow_data;
    logic [DIGITS-1:0]       shadow_mask;
    logic [3:0]              b;

    logic                    last_t;
    logic                    last_idx;
    logic                    frame;
    logic [31:0]             on_len;
    logic [31:0]             t32;
    logic                    lit;
    logic [SEG_W-1:0]        cur_seg;
    logic [DIGITS-1:0]       onehot;
    logic                    cur_mask;

    assign last_t   = (t == TW'(DWELL - 1));
    assign last_idx = (idx == IW'(DIGITS - 1));
    assign frame    = (idx == '0) && (t == '0);
    assign t32      = 32'(t);

    // 32-bit product keeps (DWELL-GUARD)*16 from overflowing for any sane DWELL
    assign on_len   = (WIN * ({28'd0, b} + 32'd1)) >> 4;

    always_comb begin
        cur_seg  = '0;
        onehot   = '0;
        cur_mask = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_seg   = shadow_data[i*SEG_W +: SEG_W];
                onehot[i] = 1'b1;
                cur_mask  = shadow_mask[i];
            end
        end
    end

    assign lit = en && cur_mask && (t32 >= G) && (t32 < G + on_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t           <= '0;
            idx         <= '0;
            shadow_data <= '0;
            shadow_mask <= '0;
            b           <= '0;
            seg_sel     <= SEL_OFF;
            seg_data    <= SEG_OFF;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else begin
            if (last_t) begin
                t   <= '0;
                idx <= last_idx ? '0 : idx + IW'(1);
            end else begin
                t <= t + TW'(1);
            end

            frame_start <= frame;
            if (frame) begin
                shadow_data <= seg_data_in;
                shadow_mask <= digit_en;
            end

            if (t == '0)
                b <= bright;

            if (lit) begin
                seg_sel  <= (SEL_ACTIVE_LOW != 0) ? ~onehot : onehot;
                seg_data <= (SEG_ACTIVE_LOW != 0) ? ~cur_seg : cur_seg;
            end else begin
                seg_sel  <= SEL_OFF;
                seg_data <= SEG_OFF;
            end

            digit_idx <= 4'(idx);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: 4 digits, DWELL=16, GUARD=2,
// active-low instance checked directly, active-high instance as complement.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [3:0]  bright;
    logic [3:0]  digit_en;
    logic [31:0] seg_data_in;

    logic [3:0]  sel_a, sel_b;
    logic [7:0]  data_a, data_b;
    logic [3:0]  didx_a, didx_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS(4), .SEG_W(8), .CLK_FREQ(3200), .SCAN_FREQ(50),
        .GUARD(2), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .rstn(rstn), .en(en), .bright(bright),
        .digit_en(digit_en), .seg_data_in(seg_data_in),
        .seg_sel(sel_a), .seg_data(data_a),
        .digit_idx(didx_a), .frame_start(fs_a)
    );

    seg_scan_ctrl #(
        .DIGITS(4), .SEG_W(8), .CLK_FREQ(3200), .SCAN_FREQ(50),
        .GUARD(2), .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut_hi (
        .clk(clk), .rstn(rstn), .en(en), .bright(bright),
        .digit_en(digit_en), .seg_data_in(seg_data_in),
        .seg_sel(sel_b), .seg_data(data_b),
        .digit_idx(didx_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
        logic [3:0] didx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: n = state count since release, fd/fm/bm = captured data
    int          n;
    logic [31:0] fd;
    logic [3:0]  fm;
    logic [3:0]  bm;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int onlen(logic [3:0] bv);
        return (14 * (int'(bv) + 1)) >> 4;
    endfunction

    task automatic step();
        int         t;
        int         i;
        logic       lit;
        logic [3:0] oh;
        exp_t       e;
        @(negedge clk);
        t   = n % 16;
        i   = (n / 16) % 4;
        lit = en && fm[i] && (t >= 2) && (t < 2 + onlen(bm));
        oh  = 4'b0001 << i;
        e.sel  = lit ? ~oh : 4'hF;
        e.data = lit ? ~fd[i*8 +: 8] : 8'hFF;
        e.didx = 4'(i);
        e.fs   = (n % 64 == 0);
        q.push_back(e);
        if (n % 64 == 0) begin
            fd = seg_data_in;
            fm = digit_en;
        end
        if (t == 0)
            bm = bright;
        n++;
        @(posedge clk);
        #2;
    endtask

    task automatic run(int k);
        repeat (k) step();
    endtask

    task automatic model_reset();
        n  = 0;
        fd = '0;
        fm = '0;
        bm = '0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_sel"}, 32'(sel_a), 32'hF);
        check({tag, "_data"}, 32'(data_a), 32'hFF);
        check({tag, "_didx"}, 32'(didx_a), 32'h0);
        check({tag, "_fs"}, 32'(fs_a), 32'h0);
        check({tag, "_sel_pol"}, 32'(sel_b), 32'h0);
        check({tag, "_data_pol"}, 32'(data_b), 32'h0);
    endtask

    exp_t       me;
    logic [3:0] nsel;
    logic [7:0] ndata;

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me    = q.pop_front();
            nsel  = ~me.sel;
            ndata = ~me.data;
            check("seg_sel", 32'(sel_a), 32'(me.sel));
            check("seg_data", 32'(data_a), 32'(me.data));
            check("digit_idx", 32'(didx_a), 32'(me.didx));
            check("frame_start", 32'(fs_a), 32'(me.fs));
            check("seg_sel_pol", 32'(sel_b), 32'(nsel));
            check("seg_data_pol", 32'(data_b), 32'(ndata));
            check("digit_idx_pol", 32'(didx_b), 32'(me.didx));
            check("frame_start_pol", 32'(fs_b), 32'(me.fs));
        end
    end

    initial begin
        rstn        = 1'b1;
        en          = 1'b0;
        bright      = 4'd0;
        digit_en    = 4'h0;
        seg_data_in = 32'h0;
        #1 rstn = 1'b0;
        #1 check_reset_outputs("reset_init");

        @(posedge clk);
        #2;
        model_reset();
        en          = 1'b1;
        bright      = 4'd15;
        digit_en    = 4'hF;
        seg_data_in = 32'h44332211;
        rstn        = 1'b1;
        run(80);

        bright = 4'd7;
        run(64);
        bright = 4'd0;
        run(64);

        bright   = 4'd15;
        digit_en = 4'b1010;
        run(64);
        digit_en = 4'hF;
        run(64);

        run(21);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(33);

        run((64 - (n % 64)) % 64);
        run(40);
        seg_data_in = 32'h88776655;
        run(88);

        run(((6 - (n % 16)) + 16) % 16 + 16);
        check("lit_before_reset", 32'(sel_a != 4'hF), 32'h1);
        rstn = 1'b0;
        #1 check_reset_outputs("reset_mid");
        check("queue_empty_reset", 32'(q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        rstn = 1'b1;
        run(80);

        #20;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
